align_shift_ctrl: RTL and testbench
===================================

Name: align_shift_ctrl

Overview:
Sequencer for the Q and R 4-base shift registers of the alignment datapath. On `start` it fetches query and reference bases from two 1-cycle-latency sequence memories. It serially preloads both registers with 4 bases each, then slides R one base per comparison step under a valid/ready handshake with the downstream scorer. Sits between the sequence memories and the two shift register instances; the shift register ports are driven directly from this block.

Parameters:
ADDR_W, 10, sequence memory address width; lengths are ADDR_W+1 bits wide.
WIN, 4, window depth in bases (matches the shift register); fixed at 4 in this revision.
PAD, 3'b111, base code shifted in when the index is at or beyond the sequence length.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
q_len  input  ADDR_W+1  query length in bases; sampled on accepted start
r_len  input  ADDR_W+1  reference length in bases; sampled on accepted start
busy  output  1  high from the cycle after start is accepted until DONE exits
done  output  1  one-cycle pulse in DONE
q_rd_en  output  1  query memory read strobe
q_addr  output  ADDR_W  query read address
q_data  input  3  query base, valid the cycle after q_rd_en
r_rd_en  output  1  reference memory read strobe
r_addr  output  ADDR_W  reference read address
r_data  input  3  reference base, valid the cycle after r_rd_en
q_sr_en  output  1  Q shift register enable
q_sr_dir  output  1  tied 0 (right shift)
q_sr_in  output  3  Q serial base
r_sr_en  output  1  R shift register enable
r_sr_dir  output  1  tied 1 (left shift)
r_sr_in  output  3  R serial base
step_valid  output  1  both windows valid for comparison
step_ready  input  1  scorer accepts the current step
step_idx  output  ADDR_W+1  R offset of the current window

Behaviour:
- Reset (synchronous, active-high): state IDLE, all outputs 0 except the tied dir bits; counters cleared. Read data returning after reset is ignored.
- States: IDLE, LOAD, SETTLE, STEP, SHIFT, DONE.
- IDLE: when start=1, latch lengths, clear counters, go to LOAD. Start is ignored in every other state.
- LOAD, 4 cycles, k = 0..3:
  - q_rd_en = (k < q_len), q_addr = k.
  - r_rd_en = (k < r_len), r_addr = k.
- Shift timing: each issued or padded slot produces sr_en the following cycle.
  - sr_in = memory data if the slot was read, else PAD.
  - Q and R therefore each receive exactly 4 shifts, in cycles LOAD+1 .. SETTLE.
- SETTLE: 1 cycle; the last preload shift occurs here. Then go to STEP.
- Resulting register layout: first query base in Q[2:0]; first reference base in R[11:9].
- Step count: N = 1 if r_len <= 4, else r_len - 3.
- STEP: step_valid = 1, step_idx = s (starts at 0). No shifts occur while step_valid is high.
  - Handshake when step_valid && step_ready.
  - If s == N-1 on the handshake, go to DONE.
  - Otherwise issue r read at address s+4 (PAD slot if s+4 >= r_len), s <= s+1, go to SHIFT.
- SHIFT: r_sr_en = 1 with r_data (or PAD); step_valid = 0; return to STEP. Steady-state throughput is 1 step per 2 cycles.
- DONE: done = 1 for one cycle, busy = 0, go to IDLE.
- step_ready low holds STEP indefinitely; step_valid and step_idx stay stable.
- q_len = 0 or r_len = 0: all slots are PAD, no reads issued; N = 1 step is still presented.
- A length wider than 2^ADDR_W is clamped to 2^ADDR_W.
- Reset asserted mid-operation: the next cycle is IDLE with no shift enables, even if a read was outstanding.
- q_sr_en and r_sr_en are never asserted outside the LOAD+1..SETTLE and SHIFT cycles.

Decomposition:
- Shared package: base code constants (A, C, G, T, N, PAD), the WIN constant, and the state encoding.
- One natural sub-module, `seq_fetch_slot`. It takes an index, length, rd_en and data, and produces the registered valid/PAD selection that yields sr_en/sr_in one cycle after a slot is issued.
- Instantiate `seq_fetch_slot` twice, once for Q and once for R.

Test Plan:
- q_len=4, r_len=4, Q=ACGT, R=ACGT, step_ready=1 → after 5 cycles Q and R hold the sequence in the specified layout; exactly one step with step_idx=0; done pulses 1 cycle later.
- r_len=7, step_ready=1 → 4 steps with step_idx 0..3, spaced 2 cycles apart; R reads at addresses 4, 5, 6; done after the last handshake.
- r_len=7, step_ready low for 5 cycles at step 1 → step_valid held with step_idx=1 and no r_sr_en; resumes normally when step_ready rises.
- q_len=2, r_len=0 → q reads at addresses 0 and 1 only; Q upper two slots are PAD; R is all 3'b111; one step, then done.
- rst=1 in the cycle after the third LOAD read → next cycle IDLE, all enables 0; a following start reloads cleanly from address 0.
- start pulsed while busy → ignored; step count and addresses unchanged.

Source files
------------

// File: rtl/align_shift_ctrl_pkg.sv
// Shared types for the alignment shift-register sequencer:
// base codes, window depth and controller state encoding.
package align_shift_ctrl_pkg;

  localparam int WIN = 4;

  typedef logic [2:0] base_t;

  localparam base_t BASE_A   = 3'd0;
  localparam base_t BASE_C   = 3'd1;
  localparam base_t BASE_G   = 3'd2;
  localparam base_t BASE_T   = 3'd3;
  localparam base_t BASE_N   = 3'd4;
  localparam base_t BASE_PAD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_STEP,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/align_shift_ctrl_if.sv
// Memory read ports and scorer step handshake of the
// alignment shift-register sequencer.
interface align_shift_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  import align_shift_ctrl_pkg::*;

  logic              q_rd_en;
  logic [ADDR_W-1:0] q_addr;
  base_t             q_data;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  base_t             r_data;
  logic              step_valid;
  logic              step_ready;
  logic [ADDR_W:0]   step_idx;

  modport master (
    output q_rd_en, q_addr,
    input  q_data,
    output r_rd_en, r_addr,
    input  r_data,
    output step_valid, step_idx,
    input  step_ready
  );

  modport slave (
    input  q_rd_en, q_addr,
    output q_data,
    input  r_rd_en, r_addr,
    output r_data,
    input  step_valid, step_idx,
    output step_ready
  );

endinterface

// File: rtl/align_shift_ctrl_slot.sv
// One fetch slot: issues a read when the index is inside the
// sequence, then presents memory data or PAD one cycle later.
module seq_fetch_slot
  import align_shift_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot,
  input  logic [ADDR_W:0]   idx,
  input  logic [ADDR_W:0]   len,
  input  base_t             data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              sr_en,
  output base_t             sr_in
);

  logic hit;
  logic en_d, en_q;
  logic pad_d, pad_q;

  assign hit   = idx < len;
  assign rd_en = slot && hit;
  assign addr  = rd_en ? idx[ADDR_W-1:0] : '0;

  always_comb begin
    en_d  = slot;
    pad_d = slot && !hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      pad_q <= 1'b0;
    end else begin
      en_q  <= en_d;
      pad_q <= pad_d;
    end
  end

  assign sr_en = en_q;
  assign sr_in = !en_q ? '0 :
                 (pad_q ? BASE_PAD : data);

endmodule

// File: rtl/align_shift_ctrl.sv
// Sequencer that preloads the Q/R shift registers from the
// sequence memories and slides R once per accepted step.
module align_shift_ctrl
  import align_shift_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ADDR_W:0] q_len,
  input  logic [ADDR_W:0] r_len,
  output logic            busy,
  output logic            done,
  output logic            q_sr_en,
  output logic            q_sr_dir,
  output base_t           q_sr_in,
  output logic            r_sr_en,
  output logic            r_sr_dir,
  output base_t           r_sr_in,
  align_shift_ctrl_if.master bus
);

  localparam logic [ADDR_W:0] LEN_MAX =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WIN_L =
    (ADDR_W+1)'(WIN);

  function automatic logic [ADDR_W:0] clamp_len(
    input logic [ADDR_W:0] l
  );
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  state_e          state_d, state_q;
  logic [1:0]      k_d, k_q;
  logic [ADDR_W:0] s_d, s_q;
  logic [ADDR_W:0] q_len_d, q_len_q;
  logic [ADDR_W:0] r_len_d, r_len_q;
  logic [ADDR_W:0] last_d, last_q;
  logic [ADDR_W:0] q_len_c, r_len_c;
  logic [ADDR_W:0] q_idx, r_idx;
  logic            q_slot, r_slot;
  logic            step_valid;

  logic              q_rd_en, r_rd_en;
  logic [ADDR_W-1:0] q_addr, r_addr;

  assign q_len_c = clamp_len(q_len);
  assign r_len_c = clamp_len(r_len);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    s_d        = s_q;
    q_len_d    = q_len_q;
    r_len_d    = r_len_q;
    last_d     = last_q;
    q_slot     = 1'b0;
    r_slot     = 1'b0;
    q_idx      = '0;
    r_idx      = '0;
    step_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          q_len_d = q_len_c;
          r_len_d = r_len_c;
          // last step index is N-1
          last_d  = (r_len_c <= WIN_L) ? '0
                    : r_len_c - WIN_L;
          k_d     = '0;
          s_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy   = 1'b1;
        q_slot = 1'b1;
        r_slot = 1'b1;
        q_idx  = {{(ADDR_W-1){1'b0}}, k_q};
        r_idx  = {{(ADDR_W-1){1'b0}}, k_q};
        k_d    = k_q + 2'd1;
        if (k_q == 2'd3) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        busy    = 1'b1;
        state_d = S_STEP;
      end
      S_STEP: begin
        busy       = 1'b1;
        step_valid = 1'b1;
        if (bus.step_ready) begin
          if (s_q == last_q) begin
            state_d = S_DONE;
          end else begin
            r_slot  = 1'b1;
            r_idx   = s_q + WIN_L;
            s_d     = s_q + 1'b1;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        state_d = S_STEP;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      q_len_q <= '0;
      r_len_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      q_len_q <= q_len_d;
      r_len_q <= r_len_d;
      last_q  <= last_d;
    end
  end

  seq_fetch_slot #(.ADDR_W(ADDR_W)) u_q_slot (
    .clk   (clk),
    .rst   (rst),
    .slot  (q_slot),
    .idx   (q_idx),
    .len   (q_len_q),
    .data  (bus.q_data),
    .rd_en (q_rd_en),
    .addr  (q_addr),
    .sr_en (q_sr_en),
    .sr_in (q_sr_in)
  );

  seq_fetch_slot #(.ADDR_W(ADDR_W)) u_r_slot (
    .clk   (clk),
    .rst   (rst),
    .slot  (r_slot),
    .idx   (r_idx),
    .len   (r_len_q),
    .data  (bus.r_data),
    .rd_en (r_rd_en),
    .addr  (r_addr),
    .sr_en (r_sr_en),
    .sr_in (r_sr_in)
  );

  assign bus.q_rd_en    = q_rd_en;
  assign bus.q_addr     = q_addr;
  assign bus.r_rd_en    = r_rd_en;
  assign bus.r_addr     = r_addr;
  assign bus.step_valid = step_valid;
  assign bus.step_idx   = step_valid ? s_q : '0;

  assign q_sr_dir = 1'b0;
  assign r_sr_dir = 1'b1;

endmodule

// File: tb/tb_align_shift_ctrl.sv
// Directed scoreboard bench for align_shift_ctrl with memory
// and shift-register models.
module tb_align_shift_ctrl;
  import align_shift_ctrl_pkg::*;

  localparam int AW  = 10;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   q_len = '0;
  logic [AW:0]   r_len = '0;
  logic          busy, done;
  logic          q_sr_en, q_sr_dir;
  logic          r_sr_en, r_sr_dir;
  base_t         q_sr_in, r_sr_in;

  align_shift_ctrl_if #(.ADDR_W(AW)) bus ();

  align_shift_ctrl #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .q_len    (q_len),
    .r_len    (r_len),
    .busy     (busy),
    .done     (done),
    .q_sr_en  (q_sr_en),
    .q_sr_dir (q_sr_dir),
    .q_sr_in  (q_sr_in),
    .r_sr_en  (r_sr_en),
    .r_sr_dir (r_sr_dir),
    .r_sr_in  (r_sr_in),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  base_t qmem [MEM];
  base_t rmem [MEM];

  always @(posedge clk) begin
    bus.q_data <= bus.q_rd_en ? qmem[bus.q_addr] : 3'b101;
    bus.r_data <= bus.r_rd_en ? rmem[bus.r_addr] : 3'b101;
  end

  logic [11:0] qsr = '0;
  logic [11:0] rsr = '0;

  always @(posedge clk) begin
    if (q_sr_en) qsr <= {q_sr_in, qsr[11:3]};
    if (r_sr_en) rsr <= {rsr[8:0], r_sr_in};
  end

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int exp_r[$];
  int exp_i[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic base_t qb(input int i, input int l);
    return (i < l) ? qmem[i] : BASE_PAD;
  endfunction

  function automatic base_t rb(input int i, input int l);
    return (i >= 0 && i < l) ? rmem[i] : BASE_PAD;
  endfunction

  function automatic logic [11:0] qwin(input int l);
    return {qb(3, l), qb(2, l), qb(1, l), qb(0, l)};
  endfunction

  function automatic logic [11:0] rwin(input int s,
                                       input int l);
    return {rb(s, l), rb(s+1, l), rb(s+2, l), rb(s+3, l)};
  endfunction

  task automatic run_test(input int ql, input int rl,
                          input int stall_at,
                          input int stall_n,
                          input bit poke);
    int  qc, rc, n, last_hs, stall_left, gap;
    bit  got_done, poked, stalled;
    qc = (ql > MEM) ? MEM : ql;
    rc = (rl > MEM) ? MEM : rl;
    n  = (rc <= 4) ? 1 : rc - 3;
    exp_q.delete();
    exp_r.delete();
    exp_i.delete();
    for (int k = 0; k < 4; k++) begin
      if (k < qc) exp_q.push_back(k);
      if (k < rc) exp_r.push_back(k);
    end
    for (int s = 0; s < n - 1; s++)
      if (s + 4 < rc) exp_r.push_back(s + 4);
    for (int s = 0; s < n; s++) exp_i.push_back(s);
    stall_left = stall_n;
    last_hs    = -1;
    got_done   = 1'b0;
    poked      = 1'b0;
    @(negedge clk);
    q_len = (AW+1)'(ql);
    r_len = (AW+1)'(rl);
    start = 1'b1;
    for (int cyc = 0; cyc < 4*n + 40 + stall_n; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      stalled = bus.step_valid &&
                bus.step_idx == stall_at &&
                stall_left > 0;
      bus.step_ready = !stalled;
      if (poke && !poked && bus.step_valid &&
          bus.step_idx == 1) begin
        start = 1'b1;
        q_len = 11'd5;
        r_len = 11'd9;
        poked = 1'b1;
      end
      #1;
      if (cyc == 0) chk("busy_load", busy, 1);
      if (bus.q_rd_en) begin
        if (exp_q.size() == 0)
          chk("q_extra_read", bus.q_addr, 9999);
        else
          chk("q_addr", bus.q_addr, exp_q.pop_front());
      end
      if (bus.r_rd_en) begin
        if (exp_r.size() == 0)
          chk("r_extra_read", bus.r_addr, 9999);
        else
          chk("r_addr", bus.r_addr, exp_r.pop_front());
      end
      if (bus.step_valid) begin
        chk("no_shift_in_step", {q_sr_en, r_sr_en}, 0);
        if (stalled) begin
          stall_left--;
          chk("stall_idx", bus.step_idx, stall_at);
        end else begin
          int s;
          s = (exp_i.size() > 0) ? exp_i.pop_front() : -1;
          chk("step_idx", bus.step_idx, s);
          chk("q_window", qsr, qwin(qc));
          chk("r_window", rsr, rwin(s, rc));
          gap = (s == stall_at) ? stall_n : 0;
          chk("step_cycle", cyc,
              ((last_hs < 0) ? 5 : last_hs + 2) + gap);
          last_hs = cyc;
        end
      end
      if (done) begin
        chk("busy_in_done", busy, 0);
        chk("done_after_last", cyc, last_hs + 1);
        got_done = 1'b1;
        break;
      end
    end
    chk("done_seen", got_done, 1);
    chk("q_reads_left", exp_q.size(), 0);
    chk("r_reads_left", exp_r.size(), 0);
    chk("steps_left", exp_i.size(), 0);
    @(negedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    bus.step_ready = 1'b0;
    for (int i = 0; i < MEM; i++) begin
      qmem[i] = base_t'($urandom_range(0, 4));
      rmem[i] = base_t'($urandom_range(0, 4));
    end
    qmem[0] = BASE_A; qmem[1] = BASE_C;
    qmem[2] = BASE_G; qmem[3] = BASE_T;
    rmem[0] = BASE_A; rmem[1] = BASE_C;
    rmem[2] = BASE_G; rmem[3] = BASE_T;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", {bus.q_rd_en, bus.r_rd_en}, 0);
    chk("rst_sr_en", {q_sr_en, r_sr_en}, 0);
    chk("rst_valid", bus.step_valid, 0);
    chk("rst_dirs", {q_sr_dir, r_sr_dir}, 2'b01);
    rst = 1'b0;

    run_test(4, 4, -1, 0, 1'b0);
    chk("acgt_q", qsr, 12'b011_010_001_000);
    run_test(4, 7, -1, 0, 1'b0);
    run_test(4, 7, 1, 5, 1'b0);
    run_test(2, 0, -1, 0, 1'b0);
    chk("pad_r", rsr, 12'hfff);

    @(negedge clk);
    q_len = 11'd4;
    r_len = 11'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("third_read_addr", bus.q_addr, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sr_en", {q_sr_en, r_sr_en}, 0);
    chk("midrst_rd", {bus.q_rd_en, bus.r_rd_en}, 0);
    chk("midrst_valid", bus.step_valid, 0);
    rst = 1'b0;

    run_test(3, 6, -1, 0, 1'b0);
    run_test(4, 7, -1, 0, 1'b1);
    run_test(0, 2047, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
